pzcorebus_response_packet_fifo: RTL and testbench
=================================================

# pzcorebus_response_packet_fifo

Packet-aware response FIFO between a corebus response master (downstream target) and a response slave (upstream initiator). It buffers response beats like the plain response FIFO. It adds a selectable release mode: cut-through, or store-and-forward, where a packet (beats up to and including `sresp_last[0]`) is not presented upstream until it is completely buffered. It also exposes word and packet occupancy, and has a deadlock-free release for packets longer than the buffer.

## Interface
- `BUS_CONFIG`, `'0`: corebus configuration; sets the packed response width via `get_packed_response_width`.
- `RESPONSE_DEPTH`, 4: buffer depth in beats.
- `RESPONSE_THRESHOLD`, `RESPONSE_DEPTH`: `o_almost_full` asserts when word count ≥ threshold.
- `RESPONSE_VALID`, 1: 0 means no storage (pass-through).
- `RELEASE_MODE`, `PZCOREBUS_CUT_THROUGH`: `PZCOREBUS_CUT_THROUGH` or `PZCOREBUS_STORE_AND_FORWARD`.
- `FLAG_FF_OUT`, 1: registered flags, forwarded to the inner FIFO.
- `DATA_FF_OUT`, 1: registered read data, forwarded to the inner FIFO.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_clear` in 1: synchronous flush.
- `o_empty` out 1: no beats stored.
- `o_almost_full` out 1: word count ≥ `RESPONSE_THRESHOLD`.
- `o_full` out 1: word count = `RESPONSE_DEPTH`.
- `o_word_count` out `$clog2(RESPONSE_DEPTH+1)`: beats stored.
- `o_packet_count` out `$clog2(RESPONSE_DEPTH+1)`: complete packets stored.
- `o_oversize` out 1: one-cycle pulse on entry to the FORWARD state.
- `slave_if` `interface.response_slave`: upstream side.
- `master_if` `interface.response_master`: downstream side.

## Operation
- Push happens when `master_if.sresp_valid && mresp_accept`, with `mresp_accept = !full`.
- Pop happens when `slave_if.sresp_valid && slave_if.mresp_accept`.
- Data order is strict FIFO. Beats are never reordered or dropped.
- A beat is a packet end when its `sresp_last[0]` is 1.
- Packet counter:
  - +1 on a push of an end beat; −1 on a pop of an end beat.
  - Both in the same cycle leaves it unchanged.
  - It never exceeds the word count.
- Cut-through mode: `sresp_valid = !empty`. The packet counter is still maintained.
- Store-and-forward mode uses a state machine, reset state HOLD:
  - HOLD: `sresp_valid = !empty && packet_count != 0`.
  - HOLD→FORWARD when `full && packet_count == 0`. This is a packet longer than the depth; `o_oversize` pulses.
  - FORWARD: `sresp_valid = !empty`.
  - FORWARD→HOLD on the pop of an end beat.
- `i_clear`:
  - Next edge gives empty, both counts 0, and state HOLD.
  - Takes priority over a push or pop in the same cycle.
- Pass-through, when `RESPONSE_VALID == 0` or `RESPONSE_DEPTH < 1`:
  - Wires: `slave sresp_valid = master sresp_valid`, `mresp_accept = slave mresp_accept`, and data passes straight through.
  - `o_empty = 1`; `o_almost_full`, `o_full`, both counts and `o_oversize` are 0.
  - Release mode is ignored.

## Timing
- Reset values: `o_empty` 1; `o_almost_full`, `o_full`, `o_oversize` 0; both counts 0; `slave sresp_valid` 0; `master mresp_accept` 1; state HOLD.
- Cut-through latency: a beat pushed at edge N is visible upstream in the cycle after N (1-cycle latency).
- Store-and-forward latency: the first beat is visible in the cycle after the edge that pushed the end beat.
- A single-beat packet has 1-cycle latency in both modes.
- Full: a simultaneous push and pop while full is not possible because accept is low. A pop while full re-raises accept on the following cycle (`FLAG_FF_OUT=1`).
- Empty: a push into an empty FIFO never bypasses to the output in the same cycle.
- Counter updates are visible the cycle after the qualifying edge.
- The release decision uses the registered `packet_count`.
- Reset asserted mid-packet: all state drops immediately (asynchronous). Partially buffered beats are discarded.

## Structure
- In `pzcorebus_pkg`: `typedef enum logic {PZCOREBUS_CUT_THROUGH, PZCOREBUS_STORE_AND_FORWARD} pzcorebus_release_mode`.
- The existing `get_packed_response_width` is reused.
- Local to the module: the HOLD/FORWARD state enum and the extraction of `sresp_last[0]` from the packed response.
- Sub-module: one `pzbcm_fifo` for beat storage, which supplies `o_word_count` and the flags.
- Packet counter and FSM sit in the wrapper.

## Test plan
- Cut-through, depth 4: push a 3-beat packet on consecutive cycles → `sresp_valid` 1 the cycle after the first push; beats popped in order; `o_packet_count` 0→1→0.
- Store-and-forward, depth 4: push 3 beats with upstream accept held 1 → `sresp_valid` stays 0 until the cycle after the last push. Then 3 beats are popped in order and `o_packet_count` returns to 0.
- Store-and-forward, depth 4, 6-beat packet: after 4 pushes → `o_full` 1, `o_oversize` one pulse, FORWARD entered. All 6 beats delivered; state returns to HOLD after the end beat pops.
- Store-and-forward simultaneous events: pop the end beat of packet A while pushing the end beat of packet B → `o_packet_count` unchanged at 1; B is released next.
- `i_clear` with 2 words and 1 packet stored, plus a concurrent push → next cycle `o_empty` 1, counts 0, and the pushed beat is discarded.
- Pass-through (`RESPONSE_VALID=0`): random valid/accept → upstream signals equal downstream signals combinationally; `o_empty` 1 and counts 0 throughout.

Source files
------------

// File: rtl/pzcorebus_pkg.sv
// rtl/pzcorebus_pkg.sv - corebus configuration, release mode and response packing helpers
package pzcorebus_pkg;
  typedef struct packed {
    int id_width;
    int data_width;
  } pzcorebus_config;

  typedef enum logic {
    PZCOREBUS_CUT_THROUGH,
    PZCOREBUS_STORE_AND_FORWARD
  } pzcorebus_release_mode;

  localparam int PZCOREBUS_SRESP_WIDTH        = 2;
  localparam int PZCOREBUS_LAST_WIDTH         = 1;
  localparam int PZCOREBUS_DEFAULT_ID_WIDTH   = 4;
  localparam int PZCOREBUS_DEFAULT_DATA_WIDTH = 32;

  // A zero field in the configuration selects the default width.
  function automatic int get_id_width(pzcorebus_config cfg);
    return (cfg.id_width > 0) ? cfg.id_width : PZCOREBUS_DEFAULT_ID_WIDTH;
  endfunction

  function automatic int get_data_width(pzcorebus_config cfg);
    return (cfg.data_width > 0) ? cfg.data_width : PZCOREBUS_DEFAULT_DATA_WIDTH;
  endfunction

  function automatic int get_packed_response_width(pzcorebus_config cfg);
    return PZCOREBUS_SRESP_WIDTH + get_id_width(cfg) + get_data_width(cfg) + PZCOREBUS_LAST_WIDTH;
  endfunction
endpackage

// File: rtl/pzcorebus_response_packet_fifo_if.sv
// rtl/pzcorebus_response_packet_fifo_if.sv - corebus response channel with master/slave modports
interface pzcorebus_response_packet_fifo_if
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG = '0
);
  localparam int ID_WIDTH   = get_id_width(BUS_CONFIG);
  localparam int DATA_WIDTH = get_data_width(BUS_CONFIG);

  logic                             sresp_valid;
  logic                             mresp_accept;
  logic [PZCOREBUS_SRESP_WIDTH-1:0] sresp;
  logic [ID_WIDTH-1:0]              sid;
  logic [DATA_WIDTH-1:0]            sdata;
  logic [PZCOREBUS_LAST_WIDTH-1:0]  sresp_last;

  modport response_slave (
    output sresp_valid, sresp, sid, sdata, sresp_last,
    input  mresp_accept
  );

  modport response_master (
    input  sresp_valid, sresp, sid, sdata, sresp_last,
    output mresp_accept
  );
endinterface

// File: rtl/pzbcm_fifo.sv
// rtl/pzbcm_fifo.sv - circular-buffer FIFO with word count, flags and optional registered outputs
module pzbcm_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int THRESHOLD   = DEPTH,
  parameter bit FLAG_FF_OUT = 1,
  parameter bit DATA_FF_OUT = 1,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_full,
  output logic [CW-1:0]    o_word_count,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_en      = i_push && (count_q != CW'(DEPTH));
  assign pop_en       = i_pop && (count_q != '0);
  assign o_word_count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_en)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_en && !i_clear) mem_q[wr_ptr_q] <= i_data;
  end

  generate
    if (FLAG_FF_OUT) begin : g_flag_ff
      logic empty_q, almost_full_q, full_q;
      logic empty_d, almost_full_d, full_d;
      always_comb begin
        empty_d       = (count_d == '0);
        almost_full_d = (int'(count_d) >= THRESHOLD);
        full_d        = (count_d == CW'(DEPTH));
      end
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          empty_q       <= 1'b1;
          almost_full_q <= 1'b0;
          full_q        <= 1'b0;
        end else begin
          empty_q       <= empty_d;
          almost_full_q <= almost_full_d;
          full_q        <= full_d;
        end
      end
      assign o_empty       = empty_q;
      assign o_almost_full = almost_full_q;
      assign o_full        = full_q;
    end else begin : g_flag_comb
      assign o_empty       = (count_q == '0);
      assign o_almost_full = (int'(count_q) >= THRESHOLD);
      assign o_full        = (count_q == CW'(DEPTH));
    end

    if (DATA_FF_OUT) begin : g_data_ff
      logic [WIDTH-1:0] data_q, data_d;
      // The next head slot may be the one being written right now; forward the input then.
      always_comb begin
        data_d = data_q;
        if (!i_clear) begin
          if (push_en && (rd_ptr_d == wr_ptr_q)) data_d = i_data;
          else                                   data_d = mem_q[rd_ptr_d];
        end
      end
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) data_q <= '0;
        else          data_q <= data_d;
      end
      assign o_data = data_q;
    end else begin : g_data_comb
      assign o_data = mem_q[rd_ptr_q];
    end
  endgenerate
endmodule

// File: rtl/pzcorebus_response_packet_fifo.sv
// rtl/pzcorebus_response_packet_fifo.sv - response FIFO with packet counting and cut-through/store-and-forward release
module pzcorebus_response_packet_fifo
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config       BUS_CONFIG         = '0,
  parameter int                    RESPONSE_DEPTH     = 4,
  parameter int                    RESPONSE_THRESHOLD = RESPONSE_DEPTH,
  parameter bit                    RESPONSE_VALID     = 1,
  parameter pzcorebus_release_mode RELEASE_MODE       = PZCOREBUS_CUT_THROUGH,
  parameter bit                    FLAG_FF_OUT        = 1,
  parameter bit                    DATA_FF_OUT        = 1,
  localparam int                   CW                 = $clog2(RESPONSE_DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  output logic          o_empty,
  output logic          o_almost_full,
  output logic          o_full,
  output logic [CW-1:0] o_word_count,
  output logic [CW-1:0] o_packet_count,
  output logic          o_oversize,
  pzcorebus_response_packet_fifo_if.response_slave  slave_if,
  pzcorebus_response_packet_fifo_if.response_master master_if
);
  localparam int WIDTH = get_packed_response_width(BUS_CONFIG);

  typedef enum logic {
    HOLD,
    FORWARD
  } state_e;

  generate
    if (RESPONSE_VALID && (RESPONSE_DEPTH >= 1)) begin : g_fifo
      logic [WIDTH-1:0] push_data, pop_data;
      logic             push, pop, push_end, pop_end;
      logic             empty, full, release_ok;
      logic [CW-1:0]    packet_count_q, packet_count_d;
      state_e           state_q, state_d;
      logic             oversize_q, oversize_d;

      // sresp_last sits in bit 0 of the packed beat.
      assign push_data = {master_if.sresp, master_if.sid, master_if.sdata, master_if.sresp_last};
      assign {slave_if.sresp, slave_if.sid, slave_if.sdata, slave_if.sresp_last} = pop_data;
      assign push_end  = push && push_data[0];
      assign pop_end   = pop && pop_data[0];

      assign master_if.mresp_accept = !full;
      assign push = master_if.sresp_valid && !full;
      assign pop  = slave_if.sresp_valid && slave_if.mresp_accept;

      pzbcm_fifo #(
        .WIDTH       (WIDTH),
        .DEPTH       (RESPONSE_DEPTH),
        .THRESHOLD   (RESPONSE_THRESHOLD),
        .FLAG_FF_OUT (FLAG_FF_OUT),
        .DATA_FF_OUT (DATA_FF_OUT)
      ) u_fifo (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clear       (i_clear),
        .o_empty       (empty),
        .o_almost_full (o_almost_full),
        .o_full        (full),
        .o_word_count  (o_word_count),
        .i_push        (push),
        .i_data        (push_data),
        .i_pop         (pop),
        .o_data        (pop_data)
      );

      always_comb begin
        packet_count_d = packet_count_q;
        state_d        = state_q;
        oversize_d     = 1'b0;
        if (i_clear) begin
          packet_count_d = '0;
          state_d        = HOLD;
        end else begin
          case ({push_end, pop_end})
            2'b10:   packet_count_d = packet_count_q + CW'(1);
            2'b01:   packet_count_d = packet_count_q - CW'(1);
            default: packet_count_d = packet_count_q;
          endcase
          if (RELEASE_MODE == PZCOREBUS_STORE_AND_FORWARD) begin
            case (state_q)
              // Buffer full without a complete packet: release it early or it would never drain.
              HOLD:    if (full && (packet_count_q == '0)) begin
                         state_d    = FORWARD;
                         oversize_d = 1'b1;
                       end
              FORWARD: if (pop_end) state_d = HOLD;
            endcase
          end
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          state_q        <= HOLD;
          packet_count_q <= '0;
          oversize_q     <= 1'b0;
        end else begin
          state_q        <= state_d;
          packet_count_q <= packet_count_d;
          oversize_q     <= oversize_d;
        end
      end

      always_comb begin
        release_ok = 1'b1;
        if ((RELEASE_MODE == PZCOREBUS_STORE_AND_FORWARD) && (state_q == HOLD)) begin
          release_ok = (packet_count_q != '0);
        end
      end

      assign slave_if.sresp_valid = !empty && release_ok;
      assign o_empty        = empty;
      assign o_full         = full;
      assign o_packet_count = packet_count_q;
      assign o_oversize     = oversize_q;
    end else begin : g_pass
      assign slave_if.sresp_valid   = master_if.sresp_valid;
      assign master_if.mresp_accept = slave_if.mresp_accept;
      assign slave_if.sresp         = master_if.sresp;
      assign slave_if.sid           = master_if.sid;
      assign slave_if.sdata         = master_if.sdata;
      assign slave_if.sresp_last    = master_if.sresp_last;
      assign o_empty        = 1'b1;
      assign o_almost_full  = 1'b0;
      assign o_full         = 1'b0;
      assign o_word_count   = '0;
      assign o_packet_count = '0;
      assign o_oversize     = 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_pzcorebus_response_packet_fifo.sv
// tb/tb_pzcorebus_response_packet_fifo.sv - self-checking bench for cut-through, store-and-forward and pass-through
module tb_pzcorebus_response_packet_fifo;
  import pzcorebus_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam pzcorebus_config CFG = '0;
  localparam int W     = get_packed_response_width(CFG);

  typedef struct {
    bit mv, ml, sr, clr;
    bit sv, full, ovs;
    int wc, pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel, mv, ml, sr, clr;
  logic [31:0] md;
  logic        pt_mv, pt_ml, pt_sr;
  logic [31:0] pt_md;

  pzcorebus_response_packet_fifo_if ct_s ();
  pzcorebus_response_packet_fifo_if ct_m ();
  pzcorebus_response_packet_fifo_if sf_s ();
  pzcorebus_response_packet_fifo_if sf_m ();
  pzcorebus_response_packet_fifo_if pt_s ();
  pzcorebus_response_packet_fifo_if pt_m ();

  assign ct_m.sresp_valid = mv && !sel;
  assign ct_m.sresp       = md[5:4];
  assign ct_m.sid         = md[3:0];
  assign ct_m.sdata       = md;
  assign ct_m.sresp_last  = ml;
  assign ct_s.mresp_accept = sr && !sel;
  assign sf_m.sresp_valid = mv && sel;
  assign sf_m.sresp       = md[5:4];
  assign sf_m.sid         = md[3:0];
  assign sf_m.sdata       = md;
  assign sf_m.sresp_last  = ml;
  assign sf_s.mresp_accept = sr && sel;
  assign pt_m.sresp_valid = pt_mv;
  assign pt_m.sresp       = pt_md[5:4];
  assign pt_m.sid         = pt_md[3:0];
  assign pt_m.sdata       = pt_md;
  assign pt_m.sresp_last  = pt_ml;
  assign pt_s.mresp_accept = pt_sr;

  logic          ct_empty, ct_af, ct_full, ct_ovs, sf_empty, sf_af, sf_full, sf_ovs;
  logic          pt_empty, pt_af, pt_full, pt_ovs;
  logic [CW-1:0] ct_wc, ct_pc, sf_wc, sf_pc, pt_wc, pt_pc;

  pzcorebus_response_packet_fifo #(
    .RESPONSE_DEPTH (DEPTH), .RELEASE_MODE (PZCOREBUS_CUT_THROUGH)
  ) dut_ct (
    .i_clk (clk), .i_rst_n (rst_n), .i_clear (clr && !sel),
    .o_empty (ct_empty), .o_almost_full (ct_af), .o_full (ct_full),
    .o_word_count (ct_wc), .o_packet_count (ct_pc), .o_oversize (ct_ovs),
    .slave_if (ct_s), .master_if (ct_m)
  );

  pzcorebus_response_packet_fifo #(
    .RESPONSE_DEPTH (DEPTH), .RELEASE_MODE (PZCOREBUS_STORE_AND_FORWARD)
  ) dut_sf (
    .i_clk (clk), .i_rst_n (rst_n), .i_clear (clr && sel),
    .o_empty (sf_empty), .o_almost_full (sf_af), .o_full (sf_full),
    .o_word_count (sf_wc), .o_packet_count (sf_pc), .o_oversize (sf_ovs),
    .slave_if (sf_s), .master_if (sf_m)
  );

  pzcorebus_response_packet_fifo #(
    .RESPONSE_DEPTH (DEPTH), .RESPONSE_VALID (1'b0)
  ) dut_pt (
    .i_clk (clk), .i_rst_n (rst_n), .i_clear (1'b0),
    .o_empty (pt_empty), .o_almost_full (pt_af), .o_full (pt_full),
    .o_word_count (pt_wc), .o_packet_count (pt_pc), .o_oversize (pt_ovs),
    .slave_if (pt_s), .master_if (pt_m)
  );

  logic          obs_sv, obs_acc, obs_empty, obs_af, obs_full, obs_ovs;
  logic [CW-1:0] obs_wc, obs_pc;
  logic [W-1:0]  obs_beat;
  assign obs_sv    = sel ? sf_s.sresp_valid : ct_s.sresp_valid;
  assign obs_acc   = sel ? sf_m.mresp_accept : ct_m.mresp_accept;
  assign obs_empty = sel ? sf_empty : ct_empty;
  assign obs_af    = sel ? sf_af : ct_af;
  assign obs_full  = sel ? sf_full : ct_full;
  assign obs_ovs   = sel ? sf_ovs : ct_ovs;
  assign obs_wc    = sel ? sf_wc : ct_wc;
  assign obs_pc    = sel ? sf_pc : ct_pc;
  assign obs_beat  = sel ? {sf_s.sresp, sf_s.sid, sf_s.sdata, sf_s.sresp_last}
                         : {ct_s.sresp, ct_s.sid, ct_s.sdata, ct_s.sresp_last};

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb_q[$];
  logic [31:0]  next_data = 32'h0000_1000;
  vec_t         ct_tab[$];
  vec_t         sf_tab[$];
  vec_t         v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_beat(input logic [31:0] d, input logic l);
    return {d[5:4], d[3:0], d, l};
  endfunction

  function automatic vec_t V(input bit mv_i, ml_i, sr_i, sv_i, input int wc_i, pc_i,
                             input bit full_i, ovs_i);
    vec_t r;
    r.mv = mv_i; r.ml = ml_i; r.sr = sr_i; r.clr = 1'b0;
    r.sv = sv_i; r.wc = wc_i; r.pc = pc_i; r.full = full_i; r.ovs = ovs_i;
    return r;
  endfunction

  // One cycle: drive at posedge+1, sample at posedge+4, scoreboard updated from the row's expectations.
  task automatic apply(input vec_t t, input bit s, input string tag, input int i);
    logic [W-1:0] exp_beat;
    sel = s; mv = t.mv; ml = t.ml; sr = t.sr; clr = t.clr; md = next_data;
    #3;
    chk($sformatf("%s[%0d].sresp_valid", tag, i), obs_sv, t.sv);
    chk($sformatf("%s[%0d].mresp_accept", tag, i), obs_acc, !t.full);
    chk($sformatf("%s[%0d].word_count", tag, i), obs_wc, t.wc);
    chk($sformatf("%s[%0d].packet_count", tag, i), obs_pc, t.pc);
    chk($sformatf("%s[%0d].full", tag, i), obs_full, t.full);
    chk($sformatf("%s[%0d].almost_full", tag, i), obs_af, t.wc >= DEPTH);
    chk($sformatf("%s[%0d].empty", tag, i), obs_empty, t.wc == 0);
    chk($sformatf("%s[%0d].oversize", tag, i), obs_ovs, t.ovs);
    if (t.sv && t.sr) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s[%0d].beat actual=%0h required=none (scoreboard empty)", tag, i, obs_beat);
      end else begin
        exp_beat = sb_q.pop_front();
        chk($sformatf("%s[%0d].beat", tag, i), obs_beat, exp_beat);
      end
    end
    if (t.clr) sb_q.delete();
    else if (t.mv && !t.full) sb_q.push_back(mk_beat(md, ml));
    if (t.mv && !t.full) next_data = next_data + 32'd1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Cut-through: 3-beat packet.
    ct_tab.push_back(V(1,0,0, 0,0,0, 0,0));
    ct_tab.push_back(V(1,0,0, 1,1,0, 0,0));
    ct_tab.push_back(V(1,1,0, 1,2,0, 0,0));
    ct_tab.push_back(V(0,0,1, 1,3,1, 0,0));
    ct_tab.push_back(V(0,0,1, 1,2,1, 0,0));
    ct_tab.push_back(V(0,0,1, 1,1,1, 0,0));
    ct_tab.push_back(V(0,0,0, 0,0,0, 0,0));
    // Store-and-forward: 3-beat packet held until complete.
    sf_tab.push_back(V(1,0,1, 0,0,0, 0,0));
    sf_tab.push_back(V(1,0,1, 0,1,0, 0,0));
    sf_tab.push_back(V(1,1,1, 0,2,0, 0,0));
    sf_tab.push_back(V(0,0,1, 1,3,1, 0,0));
    sf_tab.push_back(V(0,0,1, 1,2,1, 0,0));
    sf_tab.push_back(V(0,0,1, 1,1,1, 0,0));
    sf_tab.push_back(V(0,0,0, 0,0,0, 0,0));
    // 6-beat packet: fills, oversize pulse, FORWARD, then HOLD again.
    sf_tab.push_back(V(1,0,0, 0,0,0, 0,0));
    sf_tab.push_back(V(1,0,0, 0,1,0, 0,0));
    sf_tab.push_back(V(1,0,0, 0,2,0, 0,0));
    sf_tab.push_back(V(1,0,0, 0,3,0, 0,0));
    sf_tab.push_back(V(1,0,0, 0,4,0, 1,0));
    sf_tab.push_back(V(1,0,1, 1,4,0, 1,1));
    sf_tab.push_back(V(1,0,1, 1,3,0, 0,0));
    sf_tab.push_back(V(1,1,1, 1,3,0, 0,0));
    sf_tab.push_back(V(0,0,1, 1,3,1, 0,0));
    sf_tab.push_back(V(0,0,1, 1,2,1, 0,0));
    sf_tab.push_back(V(0,0,1, 1,1,1, 0,0));
    sf_tab.push_back(V(1,0,1, 0,0,0, 0,0));
    sf_tab.push_back(V(0,0,1, 0,1,0, 0,0));
    sf_tab.push_back(V(1,1,1, 0,1,0, 0,0));
    sf_tab.push_back(V(0,0,1, 1,2,1, 0,0));
    sf_tab.push_back(V(0,0,1, 1,1,1, 0,0));
    sf_tab.push_back(V(0,0,0, 0,0,0, 0,0));
    // End of A popped while end of B pushed.
    sf_tab.push_back(V(1,1,0, 0,0,0, 0,0));
    sf_tab.push_back(V(1,0,0, 1,1,1, 0,0));
    sf_tab.push_back(V(1,1,1, 1,2,1, 0,0));
    sf_tab.push_back(V(0,0,1, 1,2,1, 0,0));
    sf_tab.push_back(V(0,0,1, 1,1,1, 0,0));
    sf_tab.push_back(V(0,0,0, 0,0,0, 0,0));

    sel = 1'b0; mv = 1'b0; ml = 1'b0; sr = 1'b0; clr = 1'b0; md = '0;
    pt_mv = 1'b0; pt_ml = 1'b0; pt_sr = 1'b0; pt_md = '0;

    #12;
    chk("reset.ct_empty", ct_empty, 1'b1);
    chk("reset.ct_flags", {ct_af, ct_full, ct_ovs, ct_wc, ct_pc}, '0);
    chk("reset.ct_valid", ct_s.sresp_valid, 1'b0);
    chk("reset.ct_accept", ct_m.mresp_accept, 1'b1);
    chk("reset.sf_empty", sf_empty, 1'b1);
    chk("reset.sf_flags", {sf_af, sf_full, sf_ovs, sf_wc, sf_pc}, '0);
    chk("reset.sf_valid", sf_s.sresp_valid, 1'b0);
    chk("reset.sf_accept", sf_m.mresp_accept, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < ct_tab.size(); i++) apply(ct_tab[i], 1'b0, "ct", i);

    // Reset asserted mid-packet drops state without waiting for a clock edge.
    apply(V(1,0,0, 0,0,0, 0,0), 1'b0, "rst", 0);
    apply(V(1,0,0, 1,1,0, 0,0), 1'b0, "rst", 1);
    mv = 1'b0;
    #2; rst_n = 1'b0; #1;
    chk("rst_async.empty", ct_empty, 1'b1);
    chk("rst_async.word_count", ct_wc, 0);
    chk("rst_async.sresp_valid", ct_s.sresp_valid, 1'b0);
    chk("rst_async.mresp_accept", ct_m.mresp_accept, 1'b1);
    sb_q.delete();
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    apply(V(0,0,0, 0,0,0, 0,0), 1'b0, "rst", 2);

    for (int i = 0; i < sf_tab.size(); i++) apply(sf_tab[i], 1'b1, "sf", i);

    // Clear with 2 words / 1 packet stored and a concurrent push.
    apply(V(1,1,0, 0,0,0, 0,0), 1'b1, "clr", 0);
    apply(V(1,0,0, 1,1,1, 0,0), 1'b1, "clr", 1);
    v = V(1,0,0, 1,2,1, 0,0);
    v.clr = 1'b1;
    apply(v, 1'b1, "clr", 2);
    apply(V(0,0,0, 0,0,0, 0,0), 1'b1, "clr", 3);
    apply(V(1,1,1, 0,0,0, 0,0), 1'b1, "clr", 4);
    apply(V(0,0,1, 1,1,1, 0,0), 1'b1, "clr", 5);
    apply(V(0,0,0, 0,0,0, 0,0), 1'b1, "clr", 6);
    chk("scoreboard_drained", sb_q.size(), 0);

    for (int i = 0; i < 32; i++) begin
      pt_mv = 1'($urandom); pt_sr = 1'($urandom); pt_ml = 1'($urandom); pt_md = $urandom;
      #2;
      chk($sformatf("pt[%0d].sresp_valid", i), pt_s.sresp_valid, pt_mv);
      chk($sformatf("pt[%0d].mresp_accept", i), pt_m.mresp_accept, pt_sr);
      chk($sformatf("pt[%0d].beat", i), {pt_s.sresp, pt_s.sid, pt_s.sdata, pt_s.sresp_last},
          mk_beat(pt_md, pt_ml));
      chk($sformatf("pt[%0d].flags", i), {pt_empty, pt_af, pt_full, pt_ovs, pt_wc, pt_pc},
          {1'b1, 3'b000, {(2*CW){1'b0}}});
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
